matrix_loop: RTL and testbench

MATRIX_LOOP -- requirements
Module: matrix_loop

---
 rtl/matrix_loop_pkg.sv | 25 ++
 rtl/matrix_loop_mac.sv | 35 +++
 rtl/matrix_loop.sv | 105 ++++++++++
 tb/tb_matrix_loop.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/matrix_loop_pkg.sv
// Shared constants, FSM state type and the C-element width rule for matrix_loop.
// Optional MATRIX_LOOP_SATURATE_EN selects saturating rather than wrapping C writes.
package matrix_loop_pkg;

  localparam int IN_W  = 4;
  localparam int OUT_W = 8;
  localparam int ACC_W = 9;
  localparam int N     = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Narrow a completed 9-bit sum to a C element.
  function automatic logic [OUT_W-1:0] fit_out(input logic [ACC_W-1:0] sum);
`ifdef MATRIX_LOOP_SATURATE_EN
    fit_out = (sum > ACC_W'(255)) ? {OUT_W{1'b1}} : sum[OUT_W-1:0];
`else
    fit_out = sum[OUT_W-1:0];
`endif
  endfunction

endpackage

// File: rtl/matrix_loop_mac.sv
// 4x4 unsigned multiply with 9-bit accumulate; o_sum is the running total including
// the current product, so the caller can capture a finished dot product on the same edge.
module matrix_loop_mac
  import matrix_loop_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             i_init,
  input  logic             i_en,
  input  logic             i_clear,
  input  logic [IN_W-1:0]  i_a,
  input  logic [IN_W-1:0]  i_b,
  output logic [ACC_W-1:0] o_sum
);

  logic [ACC_W-1:0]  r_acc;
  logic [2*IN_W-1:0] w_prod;
  logic [ACC_W-1:0]  w_sum;

  assign w_prod = {{IN_W{1'b0}}, i_a} * {{IN_W{1'b0}}, i_b};
  // i_clear starts a new element: the old total is discarded rather than added.
  assign w_sum  = (i_clear ? {ACC_W{1'b0}} : r_acc) + ACC_W'(w_prod);
  assign o_sum  = w_sum;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_acc <= '0;
    end else if (i_init) begin
      r_acc <= '0;
    end else if (i_en) begin
      r_acc <= w_sum;
    end
  end

endmodule

// File: rtl/matrix_loop.sv
// Sequential 2x2 matrix multiplier C = A x B, one MAC per cycle in i/j/k loop order.
// Build option: MATRIX_LOOP_SATURATE_EN (see matrix_loop_pkg::fit_out).
module matrix_loop
  import matrix_loop_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [IN_W-1:0]  A00,
  input  logic [IN_W-1:0]  A01,
  input  logic [IN_W-1:0]  A10,
  input  logic [IN_W-1:0]  A11,
  input  logic [IN_W-1:0]  B00,
  input  logic [IN_W-1:0]  B01,
  input  logic [IN_W-1:0]  B10,
  input  logic [IN_W-1:0]  B11,
  output logic [OUT_W-1:0] C00,
  output logic [OUT_W-1:0] C01,
  output logic [OUT_W-1:0] C10,
  output logic [OUT_W-1:0] C11,
  output logic             done
);

  state_t r_state;
  logic   r_i, r_j, r_k;
  logic   r_done;
  logic [N-1:0][N-1:0][IN_W-1:0]  r_a;
  logic [N-1:0][N-1:0][IN_W-1:0]  r_b;
  logic [N-1:0][N-1:0][OUT_W-1:0] r_c;

  logic             w_accept;
  logic             w_calc;
  logic             w_last;
  logic [IN_W-1:0]  w_op_a;
  logic [IN_W-1:0]  w_op_b;
  logic [ACC_W-1:0] w_sum;

  // start is honoured only outside CALC, so a running computation cannot be disturbed.
  assign w_accept = start && (r_state != CALC);
  assign w_calc   = (r_state == CALC);
  assign w_last   = r_i && r_j && r_k;
  assign w_op_a   = r_a[r_i][r_k];
  assign w_op_b   = r_b[r_k][r_j];

  matrix_loop_mac u_mac (
    .clk     (clk),
    .rst     (rst),
    .i_init  (w_accept),
    .i_en    (w_calc),
    .i_clear (!r_k),
    .i_a     (w_op_a),
    .i_b     (w_op_b),
    .o_sum   (w_sum)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_done  <= 1'b0;
      r_i     <= 1'b0;
      r_j     <= 1'b0;
      r_k     <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_c     <= '0;
    end else if (w_accept) begin
      r_state  <= CALC;
      r_done   <= 1'b0;
      r_i      <= 1'b0;
      r_j      <= 1'b0;
      r_k      <= 1'b0;
      r_c      <= '0;
      r_a[0][0] <= A00;
      r_a[0][1] <= A01;
      r_a[1][0] <= A10;
      r_a[1][1] <= A11;
      r_b[0][0] <= B00;
      r_b[0][1] <= B01;
      r_b[1][0] <= B10;
      r_b[1][1] <= B11;
    end else begin
      case (r_state)
        CALC: begin
          if (r_k) begin
            r_c[r_i][r_j] <= fit_out(w_sum);
            r_j <= ~r_j;
            if (r_j) r_i <= ~r_i;
          end
          r_k <= ~r_k;
          if (w_last) r_state <= DONE;
        end
        // done lags the DONE state by one edge so it follows the final C write.
        DONE:    r_done  <= 1'b1;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign C00  = r_c[0][0];
  assign C01  = r_c[0][1];
  assign C10  = r_c[1][0];
  assign C11  = r_c[1][1];
  assign done = r_done;

endmodule

// File: tb/tb_matrix_loop.sv
// Scoreboard bench for matrix_loop: stimulus queues expected C and done cycle,
// a monitor checks them on each rising edge of done.
module tb_matrix_loop;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [3:0] A00 = '0, A01 = '0, A10 = '0, A11 = '0;
  logic [3:0] B00 = '0, B01 = '0, B10 = '0, B11 = '0;
  logic [7:0] C00, C01, C10, C11;
  logic       done;

  typedef struct {
    int c00; int c01; int c10; int c11;
    int due;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  logic prev_done = 1'b0;

`ifdef MATRIX_LOOP_SATURATE_EN
  localparam int ALL15 = 255;
`else
  localparam int ALL15 = 194;
`endif

  matrix_loop dut (
    .clk(clk), .rst(rst), .start(start),
    .A00(A00), .A01(A01), .A10(A10), .A11(A11),
    .B00(B00), .B01(B01), .B10(B10), .B11(B11),
    .C00(C00), .C01(C01), .C10(C10), .C11(C11),
    .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: one transaction per rising edge of done.
  always @(negedge clk) begin
    if (done && !prev_done) begin
      if (sb.size() == 0) begin
        chk("spurious_done", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("done_cycle", cyc, e.due);
        chk("C00", int'(C00), e.c00);
        chk("C01", int'(C01), e.c01);
        chk("C10", int'(C10), e.c10);
        chk("C11", int'(C11), e.c11);
        $display("txn @%0d: C=[%0d %0d; %0d %0d] exp=[%0d %0d; %0d %0d]",
                 cyc, C00, C01, C10, C11, e.c00, e.c01, e.c10, e.c11);
      end
    end
    prev_done <= done;
  end

  task automatic set_ab(input int a00, a01, a10, a11, b00, b01, b10, b11);
    A00 = 4'(a00); A01 = 4'(a01); A10 = 4'(a10); A11 = 4'(a11);
    B00 = 4'(b00); B01 = 4'(b01); B10 = 4'(b10); B11 = 4'(b11);
  endtask

  // Called at a negedge; returns at the negedge following the accept edge.
  task automatic go(input int c00, c01, c10, c11);
    exp_t e;
    e.c00 = c00; e.c01 = c01; e.c10 = c10; e.c11 = c11;
    e.due = cyc + 10;
    sb.push_back(e);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done();
    for (int t = 0; t < 40 && sb.size() != 0; t++) @(negedge clk);
    chk("timeout_pending", sb.size(), 0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_C00"}, int'(C00), 0);
    chk({tag, "_C01"}, int'(C01), 0);
    chk({tag, "_C10"}, int'(C10), 0);
    chk({tag, "_C11"}, int'(C11), 0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk_zero("reset");
    rst = 1'b1;
    @(negedge clk);
    chk_zero("idle");

    // Basic product, then hold while idle in DONE
    set_ab(1, 2, 3, 4, 5, 6, 7, 8);
    go(19, 22, 43, 50);
    wait_done();
    repeat (3) @(negedge clk);
    chk("hold_C10", int'(C10), 43);
    chk("hold_done", int'(done), 1);

    // All inputs at maximum
    set_ab(15, 15, 15, 15, 15, 15, 15, 15);
    go(ALL15, ALL15, ALL15, ALL15);
    wait_done();

    // Identity times B, then zero A
    set_ab(1, 0, 0, 1, 9, 10, 11, 12);
    go(9, 10, 11, 12);
    wait_done();
    set_ab(0, 0, 0, 0, 9, 10, 11, 12);
    go(0, 0, 0, 0);
    wait_done();

    // Start and input changes during CALC are ignored
    set_ab(1, 2, 3, 4, 5, 6, 7, 8);
    go(19, 22, 43, 50);
    repeat (2) @(negedge clk);
    start = 1'b1;
    set_ab(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    start = 1'b0;
    wait_done();

    // Reset mid-CALC clears immediately; restart gives normal result
    set_ab(1, 2, 3, 4, 5, 6, 7, 8);
    go(19, 22, 43, 50);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk_zero("midrst");
    sb.delete();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    go(19, 22, 43, 50);
    wait_done();

    // Restart from DONE with B = identity
    set_ab(1, 2, 3, 4, 1, 0, 0, 1);
    go(1, 2, 3, 4);
    chk_zero("restart");
    wait_done();

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
